// File: rtl/noc_pkg.sv
// Shared NoC link definitions: flit layout, packet states and buffer depth.
package noc_pkg;

  localparam int unsigned FLIT_W        = 16;
  localparam int unsigned TAIL_BIT      = 15;
  localparam int unsigned HEAD_BIT      = 14;
  // Depth of the neighbour input FIFO; also the reset credit count.
  localparam int unsigned NOC_BUF_DEPTH = 5;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } pkt_state_t;

endpackage

// File: rtl/noc_credit_counter.sv
// Saturating up/down credit counter with ready flag and sticky overflow error.
module noc_credit_counter #(
  parameter int unsigned CREDITS = noc_pkg::NOC_BUF_DEPTH,
  parameter int unsigned CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             take_i,
  input  logic             credit_i,
  output logic             ready_c,
  output logic [CNT_W-1:0] cnt_o,
  output logic             error_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             err_d, err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (take_i && !credit_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (!take_i && credit_i) begin
      // A credit beyond the buffer depth is a protocol violation: saturate and flag.
      if (cnt_q == CNT_W'(CREDITS)) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= CNT_W'(CREDITS);
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign ready_c = (cnt_q != '0);
  assign cnt_o   = cnt_q;
  assign error_o = err_q;

endmodule

// File: rtl/noc_output_port.sv
// NoC router output port: credit-flow-controlled flit register with packet lock.
module noc_output_port #(
  parameter int unsigned FLIT_W  = noc_pkg::FLIT_W,
  parameter int unsigned CREDITS = noc_pkg::NOC_BUF_DEPTH,
  parameter int unsigned CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              lock_o,
  output logic [FLIT_W-1:0] data_o,
  output logic              write_en_o,
  input  logic              credit_i,
  output logic [CNT_W-1:0]  credit_cnt_o,
  output logic              error_o
);

  import noc_pkg::*;

  logic              xfer_c;
  logic              ready_c;
  logic              tail_c;
  pkt_state_t        state_d, state_q;
  logic              lock_d, lock_q;
  logic [FLIT_W-1:0] data_d, data_q;
  logic              we_d, we_q;

  noc_credit_counter #(
    .CREDITS (CREDITS),
    .CNT_W   (CNT_W)
  ) u_credit (
    .clk      (clk),
    .rst_n    (rst_n),
    .take_i   (xfer_c),
    .credit_i (credit_i),
    .ready_c  (ready_c),
    .cnt_o    (credit_cnt_o),
    .error_o  (error_o)
  );

  assign xfer_c = valid_i && ready_c;
  assign tail_c = data_i[TAIL_BIT];

  // Packet FSM advances only on accepted flits; head bit is not inspected.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    we_d    = 1'b0;
    if (xfer_c) begin
      data_d = data_i;
      we_d   = 1'b1;
      case (state_q)
        IDLE:    if (!tail_c) state_d = BUSY;
        BUSY:    if (tail_c)  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    lock_d = (state_d == BUSY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lock_q  <= 1'b0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      data_q  <= data_d;
      we_q    <= we_d;
    end
  end

  assign ready_o    = ready_c;
  assign lock_o     = lock_q;
  assign data_o     = data_q;
  assign write_en_o = we_q;

endmodule

// File: tb/tb_noc_output_port.sv
// Directed and randomized checks of noc_output_port against a behavioural link model.
module tb_noc_output_port;

  localparam int unsigned FLIT_W  = 16;
  localparam int unsigned CREDITS = 5;
  localparam int unsigned CNT_W   = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [FLIT_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;
  logic              lock_o;
  logic [FLIT_W-1:0] data_o;
  logic              write_en_o;
  logic              credit_i;
  logic [CNT_W-1:0]  credit_cnt_o;
  logic              error_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int                m_cnt;
  bit                m_err;
  bit                m_in_pkt;
  bit                m_we;
  logic [FLIT_W-1:0] m_data;

  always #5 clk = ~clk;

  noc_output_port #(
    .FLIT_W  (FLIT_W),
    .CREDITS (CREDITS),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .lock_o       (lock_o),
    .data_o       (data_o),
    .write_en_o   (write_en_o),
    .credit_i     (credit_i),
    .credit_cnt_o (credit_cnt_o),
    .error_o      (error_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".cnt"},   32'(credit_cnt_o), 32'(m_cnt));
    chk({tag, ".ready"}, 32'(ready_o),      32'(m_cnt > 0));
    chk({tag, ".we"},    32'(write_en_o),   32'(m_we));
    chk({tag, ".data"},  32'(data_o),       32'(m_data));
    chk({tag, ".lock"},  32'(lock_o),       32'(m_in_pkt));
    chk({tag, ".err"},   32'(error_o),      32'(m_err));
  endtask

  task automatic do_reset(input int cycles);
    rst_n    = 1'b0;
    valid_i  = 1'b0;
    credit_i = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    m_cnt    = CREDITS;
    m_err    = 1'b0;
    m_in_pkt = 1'b0;
    m_we     = 1'b0;
    m_data   = '0;
    chk_all("reset");
  endtask

  // One clock of traffic; the model is the link rule set, not the RTL structure.
  task automatic step(input logic v, input logic [FLIT_W-1:0] d, input logic c,
                      input string tag, output logic acc);
    int nxt;
    valid_i  = v;
    data_i   = d;
    credit_i = c;
    acc = v && (m_cnt > 0);
    chk({tag, ".ready_pre"}, 32'(ready_o), 32'(m_cnt > 0));
    @(posedge clk);
    #1;
    nxt = m_cnt - int'(acc) + int'(c);
    if (nxt > int'(CREDITS)) begin
      nxt   = CREDITS;
      m_err = 1'b1;
    end
    m_cnt = nxt;
    m_we  = acc;
    if (acc) begin
      m_data   = d;
      m_in_pkt = !d[15];
    end
    chk_all(tag);
  endtask

  initial begin
    logic              acc;
    logic [FLIT_W-1:0] next_flit;
    logic [FLIT_W-1:0] rnd_flit;
    int                outstanding;

    rst_n    = 1'b0;
    valid_i  = 1'b0;
    credit_i = 1'b0;
    data_i   = '0;

    // Reset and idle
    do_reset(2);
    chk("reset.cnt5", 32'(credit_cnt_o), 32'd5);
    chk("reset.data0", 32'(data_o), 32'd0);

    // Credit exhaustion: crossbar holds its flit until accepted
    next_flit = 16'h0001;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, next_flit, 1'b0, "exhaust", acc);
      if (acc) next_flit = next_flit + 16'h0001;
    end
    chk("exhaust.cnt0", 32'(credit_cnt_o), 32'd0);
    chk("exhaust.ready0", 32'(ready_o), 32'd0);
    chk("exhaust.next", 32'(next_flit), 32'h0006);
    step(1'b1, next_flit, 1'b1, "exhaust_credit", acc);
    chk("exhaust_credit.not_same_cycle", 32'(acc), 32'd0);
    step(1'b1, next_flit, 1'b0, "exhaust_accept6", acc);
    chk("exhaust_accept6.we", 32'(write_en_o), 32'd1);
    chk("exhaust_accept6.data", 32'(data_o), 32'h0006);

    // Simultaneous accept and credit
    do_reset(1);
    step(1'b1, 16'h0011, 1'b0, "simul_a", acc);
    step(1'b1, 16'h0012, 1'b0, "simul_b", acc);
    step(1'b1, 16'h0013, 1'b1, "simul_both", acc);
    chk("simul_both.cnt3", 32'(credit_cnt_o), 32'd3);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0020 + 16'(i), 1'b0, "simul_drain", acc);
    chk("simul_drain.cnt0", 32'(credit_cnt_o), 32'd0);
    step(1'b0, 16'h0000, 1'b1, "simul_credit", acc);
    chk("simul_credit.cnt1", 32'(credit_cnt_o), 32'd1);
    chk("simul_credit.ready1", 32'(ready_o), 32'd1);

    // Packet lock, then a single-flit packet
    do_reset(1);
    step(1'b1, 16'h4001, 1'b0, "pkt_head", acc);
    chk("pkt_head.lock1", 32'(lock_o), 32'd1);
    step(1'b1, 16'h0002, 1'b0, "pkt_body", acc);
    step(1'b1, 16'h8003, 1'b0, "pkt_tail", acc);
    chk("pkt_tail.lock0", 32'(lock_o), 32'd0);
    step(1'b1, 16'hC004, 1'b1, "pkt_single", acc);
    chk("pkt_single.lock0", 32'(lock_o), 32'd0);
    step(1'b0, 16'h0000, 1'b0, "pkt_idle", acc);

    // Overflow is sticky until reset
    do_reset(1);
    step(1'b0, 16'h0000, 1'b1, "ovf", acc);
    chk("ovf.cnt5", 32'(credit_cnt_o), 32'd5);
    chk("ovf.err1", 32'(error_o), 32'd1);
    step(1'b1, 16'h0031, 1'b0, "ovf_hold_a", acc);
    step(1'b0, 16'h0000, 1'b1, "ovf_hold_b", acc);
    step(1'b0, 16'h0000, 1'b0, "ovf_hold_c", acc);
    chk("ovf_hold.err1", 32'(error_o), 32'd1);

    // Reset mid-packet
    do_reset(1);
    step(1'b1, 16'h4041, 1'b0, "mid_head", acc);
    step(1'b1, 16'h0042, 1'b0, "mid_b1", acc);
    step(1'b1, 16'h0043, 1'b0, "mid_b2", acc);
    chk("mid.cnt2", 32'(credit_cnt_o), 32'd2);
    chk("mid.lock1", 32'(lock_o), 32'd1);
    do_reset(1);
    chk("mid_rst.cnt5", 32'(credit_cnt_o), 32'd5);
    chk("mid_rst.lock0", 32'(lock_o), 32'd0);
    chk("mid_rst.we0", 32'(write_en_o), 32'd0);

    // Randomized traffic; credits normally follow outstanding flits, rarely spurious
    do_reset(1);
    outstanding = 0;
    for (int i = 0; i < 400; i++) begin
      logic v;
      logic c;
      v = ($urandom_range(0, 3) != 0);
      rnd_flit = 16'($urandom);
      c = (outstanding > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      step(v, rnd_flit, c, "rand", acc);
      outstanding = outstanding + int'(acc) - int'(c);
      if (outstanding < 0) outstanding = 0;
      if (i == 200) begin
        do_reset(1);
        outstanding = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_output_port.md
Name: noc_output_port

Overview:
- Transmit side of a NoC router link: accepts flits from the local crossbar and drives them into the neighbouring router's input port buffer (write_en/data).
- Credit-based flow control: tracks free slots in the downstream 5-deep flit FIFO, so the downstream push is never refused.
- Holds a packet lock from head flit to tail flit so the switch allocator keeps the grant for the whole packet.

Parameters:
- FLIT_W, 16, flit width in bits; must match the downstream input port.
- CREDITS, 5, downstream buffer depth; this is the reset credit count.
- CNT_W, $clog2(CREDITS+1), credit counter width (3 at default).

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- data_i  in  FLIT_W  flit from crossbar.
- valid_i  in  1  crossbar offers data_i this cycle.
- ready_o  out  1  port can accept a flit this cycle.
- lock_o  out  1  packet in progress; allocator must hold this grant.
- data_o  out  FLIT_W  flit to neighbour input port.
- write_en_o  out  1  push strobe to neighbour input port.
- credit_i  in  1  neighbour popped one flit (its shift); returns one credit.
- credit_cnt_o  out  CNT_W  current free downstream slots.
- error_o  out  1  sticky credit-overflow error.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - credit_cnt = CREDITS; state = IDLE.
  - data_o = 0; write_en_o = 0; error_o = 0.
  - Reset mid-packet drops to IDLE with credits restored; the system resets both link ends together.
- ready_o = (credit_cnt != 0). This is combinational from the register, with no dependence on valid_i.
- Accept: xfer = valid_i && ready_o.
  - valid_i while ready_o=0 is ignored; the crossbar holds the flit.
- Latency 1 cycle, registered outputs:
  - Next edge after xfer: write_en_o=1, data_o=data_i.
  - Without xfer: write_en_o=0, data_o holds its last value.
  - Back-to-back xfers give continuous write_en_o.
- Credit counter: next = cnt - xfer + credit_i.
  - xfer and credit_i in the same cycle: count unchanged.
  - A credit arriving while cnt==0 enables ready_o on the following cycle, never the same cycle.
  - credit_i while cnt==CREDITS with no xfer: count saturates at CREDITS and error_o sets.
  - error_o clears only on reset.
  - Underflow cannot occur, because xfer requires cnt!=0.
- Flit format (package): bit TAIL_BIT=15 marks a tail flit; bit HEAD_BIT=14 marks a head flit. Payload is the remaining bits and is not inspected.
- Packet FSM, evaluated on xfer only:
  - IDLE: accepted flit with tail=0 goes to BUSY; tail=1 (single-flit packet) stays IDLE.
  - BUSY: accepted flit with tail=1 goes to IDLE; otherwise stays BUSY.
  - lock_o = (state==BUSY), registered; it asserts the cycle after the head flit is accepted.
  - The head bit is not checked by the FSM.

Decomposition:
- Shared package noc_pkg:
  - FLIT_W=16, TAIL_BIT=15, HEAD_BIT=14.
  - typedef logic [FLIT_W-1:0] flit_t.
  - typedef enum {IDLE, BUSY} pkt_state_t.
  - default buffer depth constant 5, shared with the input port so CREDITS and the FIFO depth cannot diverge.
- One sub-module, noc_credit_counter:
  - holds the up/down saturating count, the ready flag and the sticky overflow.
  - reused by any future virtual-channel port.
- The FSM and output register stay in noc_output_port.

Test Plan:
- Reset and idle:
  - Stimulus: hold rst_n=0 for 2 cycles, then release.
  - Response: credit_cnt_o=5, ready_o=1, write_en_o=0, data_o=0, lock_o=0, error_o=0.
- Credit exhaustion:
  - Stimulus: valid_i=1 for 7 cycles with flits 0x0001..0x0007 (tail=0), credit_i=0.
  - Response: exactly 5 accepted; write_en_o high for 5 cycles, one cycle delayed, data 0x0001..0x0005; credit_cnt_o ends at 0 and ready_o=0.
  - Follow-up: one credit_i pulse leads to 0x0006 being accepted the next cycle.
- Simultaneous event:
  - Stimulus: with cnt=3, drive xfer and credit_i in the same cycle.
  - Response: cnt stays 3.
  - Follow-up: at cnt=0, credit_i alone leads to cnt=1 and ready_o=1 on the next cycle.
- Packet lock:
  - Stimulus: send 0x4001 (head), 0x0002, 0x8003 (tail).
  - Response: lock_o goes 1 after the first accept and 0 after the tail accept.
  - Follow-up: a single flit 0xC004 leaves lock_o at 0 throughout.
- Overflow:
  - Stimulus: at cnt=5 with no traffic, pulse credit_i.
  - Response: cnt stays 5 and error_o=1; error_o persists until reset.
- Reset mid-packet:
  - Stimulus: after head flit plus 2 body flits (cnt=2, lock_o=1), pulse rst_n=0 for one cycle.
  - Response: cnt=5, lock_o=0, write_en_o=0 on the next cycle.
